unsigned_pipelined_fixed_point_subtractor: RTL and testbench

UNSIGNED_PIPELINED_FIXED_POINT_SUBTRACTOR -- requirements
Module: unsigned_pipelined_fixed_point_subtractor

---
 rtl/unsigned_pipelined_fixed_point_subtractor_pkg.sv | 12 +
 rtl/fixed_point_half_subtractor.sv | 23 ++
 rtl/unsigned_pipelined_fixed_point_subtractor.sv | 119 +++++++++++
 tb/tb_unsigned_pipelined_fixed_point_subtractor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_pipelined_fixed_point_subtractor_pkg.sv
// Shared constants for the two-stage unsigned subtractor.
// The operand width is split into two equal halves, one per pipeline stage.
package unsigned_pipelined_fixed_point_subtractor_pkg;

    localparam int SUB_WIDTH = 8;
    localparam int SUB_HALF  = SUB_WIDTH / 2;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/fixed_point_half_subtractor.sv
// Combinational H-bit subtract with borrow chain: diff = a - b - borrow_in.
// borrow_out is the sign of the (H+1)-bit result.
module fixed_point_half_subtractor
    import unsigned_pipelined_fixed_point_subtractor_pkg::*;
#(
    parameter int H = SUB_HALF
) (
    input  logic [H-1:0] a,
    input  logic [H-1:0] b,
    input  logic         borrow_in,
    output logic [H-1:0] diff,
    output logic         borrow_out
);

    logic [H:0] wide_diff;

    always_comb begin
        wide_diff  = {1'b0, a} - {1'b0, b} - {{H{1'b0}}, borrow_in};
        diff       = wide_diff[H-1:0];
        borrow_out = wide_diff[H];
    end

endmodule

// File: rtl/unsigned_pipelined_fixed_point_subtractor.sv
// Two-stage valid/ready subtractor: S1 handles the lower half, S2 the upper
// half plus the output register. Stalls propagate backwards one stage at a time.
module unsigned_pipelined_fixed_point_subtractor
    import unsigned_pipelined_fixed_point_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
);

    localparam int H = half_width(WIDTH);

    // Stage 1 registers
    logic         s1_v_q,      s1_v_d;
    logic [H-1:0] s1_diff_q,   s1_diff_d;
    logic         s1_borrow_q, s1_borrow_d;
    logic [H-1:0] s1_a_up_q,   s1_a_up_d;
    logic [H-1:0] s1_b_up_q,   s1_b_up_d;

    // Stage 2 (output) registers
    logic         s2_v_q,      s2_v_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
    logic         borrow_q,    borrow_d;

    logic         s1_load;
    logic         s2_load;
    logic [H-1:0] lo_diff;
    logic         lo_borrow;
    logic [H-1:0] up_diff;
    logic         up_borrow;

    fixed_point_half_subtractor #(.H(H)) u_lo_sub (
        .a          (A[H-1:0]),
        .b          (B[H-1:0]),
        .borrow_in  (1'b0),
        .diff       (lo_diff),
        .borrow_out (lo_borrow)
    );

    fixed_point_half_subtractor #(.H(H)) u_up_sub (
        .a          (s1_a_up_q),
        .b          (s1_b_up_q),
        .borrow_in  (s1_borrow_q),
        .diff       (up_diff),
        .borrow_out (up_borrow)
    );

    // A stage may load when it is empty or its contents move on this cycle,
    // so an empty S1 accepts even while S2 is stalled.
    always_comb begin
        s2_load  = !s2_v_q || out_ready;
        s1_load  = !s1_v_q || s2_load;
        in_ready = s1_load;
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_diff_d   = s1_diff_q;
        s1_borrow_d = s1_borrow_q;
        s1_a_up_d   = s1_a_up_q;
        s1_b_up_d   = s1_b_up_q;
        if (s1_load) begin
            s1_v_d      = in_valid;
            s1_diff_d   = lo_diff;
            s1_borrow_d = lo_borrow;
            s1_a_up_d   = A[WIDTH-1:H];
            s1_b_up_d   = B[WIDTH-1:H];
        end
    end

    always_comb begin
        s2_v_d   = s2_v_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        if (s2_load) begin
            s2_v_d   = s1_v_q;
            diff_d   = {up_diff, s1_diff_q};
            borrow_d = up_borrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            s1_diff_q   <= '0;
            s1_borrow_q <= 1'b0;
            s1_a_up_q   <= '0;
            s1_b_up_q   <= '0;
            s2_v_q      <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_diff_q   <= s1_diff_d;
            s1_borrow_q <= s1_borrow_d;
            s1_a_up_q   <= s1_a_up_d;
            s1_b_up_q   <= s1_b_up_d;
            s2_v_q      <= s2_v_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
        end
    end

    always_comb begin
        out_valid = s2_v_q;
        Diff      = diff_q;
        Borrow    = borrow_q;
    end

endmodule

// File: tb/tb_unsigned_pipelined_fixed_point_subtractor.sv
// Self-checking bench: directed vector table, back-to-back, stall, reset and
// randomized traffic against a queue-based arithmetic reference model.
module tb_unsigned_pipelined_fixed_point_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Diff;
    logic         Borrow;

    unsigned_pipelined_fixed_point_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Borrow    (Borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
    } vec_t;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
    } res_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     n_in     = 0;
    int     n_out    = 0;
    res_t   exp_q[$];
    logic   hold_pending = 1'b0;
    logic [W-1:0] held_diff;
    logic   held_borrow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to W bits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        int   d;
        d        = int'(a) - int'(b);
        r.diff   = W'(d & ((1 << W) - 1));
        r.borrow = (int'(a) < int'(b));
        return r;
    endfunction

    // Observe one cycle at the falling edge, then step to just after the rising edge.
    task automatic tick();
        res_t e;
        @(negedge clk);
        if (hold_pending) begin
            chk("hold_valid",  out_valid, 1);
            chk("hold_diff",   Diff,      held_diff);
            chk("hold_borrow", Borrow,    held_borrow);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got diff=0x%0h borrow=%0b expected none", Diff, Borrow);
            end else begin
                e = exp_q.pop_front();
                chk("sb_diff",   Diff,   e.diff);
                chk("sb_borrow", Borrow, e.borrow);
                n_out++;
                $display("out #%0d diff=0x%02h borrow=%0b", n_out, Diff, Borrow);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(A, B));
            n_in++;
        end
        hold_pending = out_valid && !out_ready;
        held_diff    = Diff;
        held_borrow  = Borrow;
        @(posedge clk);
        #1;
    endtask

    // Single operation with an empty pipe: result must appear after exactly two edges.
    task automatic run_vec(input vec_t v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = v.a;
        B = v.b;
        #1;
        chk("vec_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("vec_lat1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("vec_lat2_valid", out_valid, 1);
        chk("vec_diff",       Diff,      v.diff);
        chk("vec_borrow",     Borrow,    v.borrow);
        $display("vec A=0x%02h B=0x%02h -> diff=0x%02h borrow=%0b", v.a, v.b, Diff, Borrow);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    vec_t b2b[3];
    vec_t stall_v[3];

    initial begin
        vecs[0] = '{8'hC8, 8'h35, 8'h93, 1'b0};
        vecs[1] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[3] = '{8'h35, 8'h35, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[5] = '{8'h01, 8'h02, 8'hFF, 1'b1};
        vecs[6] = '{8'h80, 8'h81, 8'hFF, 1'b1};
        vecs[7] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[8] = '{8'h0F, 8'h10, 8'hFF, 1'b1};
        vecs[9] = '{8'hA0, 8'h0B, 8'h95, 1'b0};
        b2b[0]  = vecs[3];
        b2b[1]  = vecs[4];
        b2b[2]  = vecs[5];
        stall_v[0] = '{8'h50, 8'h20, 8'h30, 1'b0};
        stall_v[1] = '{8'h20, 8'h50, 8'hD0, 1'b1};
        stall_v[2] = '{8'h77, 8'h11, 8'h66, 1'b0};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
        #2;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff",      Diff,      0);
        chk("rst_borrow",    Borrow,    0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table with exact latency
        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Back-to-back: one result per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k >= 2) begin
                chk("b2b_valid",  out_valid, 1);
                chk("b2b_diff",   Diff,      b2b[k-2].diff);
                chk("b2b_borrow", Borrow,    b2b[k-2].borrow);
                $display("b2b #%0d diff=0x%02h borrow=%0b", k - 2, Diff, Borrow);
            end
            if (k < 3) begin
                in_valid = 1'b1; A = b2b[k].a; B = b2b[k].b;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("b2b_third", Diff, b2b[2].diff);
        @(posedge clk);
        #1;
        chk("b2b_drained", out_valid, 0);

        // Stall: 5 cycles of out_ready=0 with 3 operands offered
        begin
            int idx;
            int cyc;
            idx = 0;
            out_ready = 1'b0;
            n_out = 0;
            for (int c = 0; c < 5; c++) begin
                in_valid = (idx < 3);
                A = stall_v[idx < 3 ? idx : 2].a;
                B = stall_v[idx < 3 ? idx : 2].b;
                #0;
                if (in_ready && in_valid) begin
                    idx++;
                    tick();
                end else begin
                    tick();
                end
            end
            chk("stall_accepted", idx, 2);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_diff", Diff, stall_v[0].diff);
            out_ready = 1'b1;
            cyc = 0;
            while ((idx < 3 || exp_q.size() != 0) && cyc < 20) begin
                in_valid = (idx < 3);
                A = stall_v[2].a;
                B = stall_v[2].b;
                #0;
                if (in_valid && in_ready) idx++;
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            chk("stall_drain_bound", (cyc < 20), 1);
            chk("stall_results", n_out, 3);
        end

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A = 8'h99; B = 8'h11;
        tick();
        tick();
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready",  in_ready,  0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_diff",      Diff,      0);
        chk("midrst_borrow",    Borrow,    0);
        exp_q.delete();
        hold_pending = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("postrst_no_stale", out_valid, 0);
        run_vec(vecs[0]);

        // Randomized traffic against the reference model
        begin
            int sent;
            int cyc;
            exp_q.delete();
            hold_pending = 1'b0;
            n_out = 0;
            sent  = 0;
            cyc   = 0;
            while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
                in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                A = W'($urandom);
                B = W'($urandom);
                #0;
                if (in_valid && in_ready) sent++;
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            chk("rand_bound", (cyc < 60000), 1);
            chk("rand_count", n_out, 10000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
